bos_power_seq: RTL and testbench

Power sequencer for the BOS board register block. It converts single-cycle power-up and power-down commands into an ordered, time-spaced series of register writes on the `master_data` / `valid_bus` write interface. The writes set the supply, level-translator, overvoltage-protection and DAC-enable controls in the correct order. It sits between the host command decoder and the FPGA register block, and shares that block's write port format.

---
 rtl/bos_power_seq.sv | 104 ++++++++++
 tb/tb_bos_power_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bos_power_seq.sv
// bos_power_seq: turns power-up/down commands into ordered, time-spaced register writes
module bos_power_seq #(
    parameter int STEP_DELAY = 1000,
    parameter int CW = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_up,
    input  logic       start_down,
    input  logic       fault,
    output logic [7:0] master_data,
    output logic [8:0] valid_bus,
    output logic       busy,
    output logic       powered,
    output logic       done
);
    localparam logic [1:0] S_OFF = 2'd0, S_UP = 2'd1, S_ON = 2'd2, S_DOWN = 2'd3;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DELAY - 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [7:0]    md_q, md_d;
    logic [8:0]    vb_q, vb_d;
    logic          busy_q, powered_q, done_q, done_d;
    logic          abort, seq, wait_end, bit_v;
    logic [3:0]    ch;

    // Sequencing: a write cycle, then STEP_DELAY wait cycles per step; aborts jump to DOWN step 0
    always_comb begin
        abort    = start_down || fault;
        seq      = (state_q == S_UP) || (state_q == S_DOWN);
        wait_end = seq && !wr_q && (cnt_q == CNT_LAST);
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        wr_d     = 1'b0;
        done_d   = 1'b0;
        if (((state_q == S_UP) || (state_q == S_ON)) && abort) begin
            state_d = S_DOWN;
            step_d  = 3'd0;
            cnt_d   = '0;
            wr_d    = 1'b1;
        end else if ((state_q == S_OFF) && start_up && !fault) begin
            state_d = S_UP;
            step_d  = 3'd0;
            cnt_d   = '0;
            wr_d    = 1'b1;
        end else if (seq && wr_q) begin
            cnt_d = '0;
        end else if (wait_end && (step_q == 3'd4)) begin
            state_d = (state_q == S_UP) ? S_ON : S_OFF;
            step_d  = 3'd0;
            cnt_d   = '0;
            done_d  = 1'b1;
        end else if (wait_end) begin
            step_d = step_q + 3'd1;
            wr_d   = 1'b1;
        end else if (seq) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Table lookup for the upcoming write; down order is the up order reversed with each value inverted
    always_comb begin
        ch    = (state_d == S_UP) ? 4'd8 - {1'b0, step_d} : 4'd4 + {1'b0, step_d};
        bit_v = (state_d == S_UP) ? (step_d == 3'd2 || step_d == 3'd4)
                                  : (step_d == 3'd1 || step_d >= 3'd3);
        vb_d  = wr_d ? 9'(1) << ch : 9'd0;
        md_d  = wr_d ? {7'd0, bit_v} : 8'h00;
    end

    // State and registered outputs; reset drops any partial sequence
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= S_OFF;
            step_q    <= 3'd0;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            md_q      <= 8'h00;
            vb_q      <= 9'd0;
            busy_q    <= 1'b0;
            powered_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            md_q      <= md_d;
            vb_q      <= vb_d;
            busy_q    <= (state_d == S_UP) || (state_d == S_DOWN);
            powered_q <= state_d == S_ON;
            done_q    <= done_d;
        end
    end

    assign master_data = md_q;
    assign valid_bus   = vb_q;
    assign busy        = busy_q;
    assign powered     = powered_q;
    assign done        = done_q;
endmodule

// File: tb/tb_bos_power_seq.sv
// tb_bos_power_seq: directed and random checks of bos_power_seq against an elapsed-time schedule model
module tb_bos_power_seq;
    localparam int D = 4;
    localparam int LAST = 5 * (D + 1) - 1;

    logic       clk = 1'b0, n_rst = 1'b0, start_up = 1'b0, start_down = 1'b0, fault = 1'b0;
    logic [7:0] master_data;
    logic [8:0] valid_bus;
    logic       busy, powered, done;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   mode = 0, ph = 0;
    logic done_e = 1'b0;
    int   up_ch[5]  = '{8, 7, 6, 5, 4};
    int   up_dat[5] = '{0, 0, 1, 0, 1};
    int   dn_ch[5]  = '{4, 5, 6, 7, 8};
    int   dn_dat[5] = '{0, 1, 0, 1, 1};
    int   last_done = -1, last_wr = -1, n_wr = 0, t0 = 0;
    logic pw_seen = 1'b0, flt = 1'b0;

    bos_power_seq #(.STEP_DELAY(D), .CW(8)) dut (
        .clk(clk), .n_rst(n_rst), .start_up(start_up), .start_down(start_down), .fault(fault),
        .master_data(master_data), .valid_bus(valid_bus), .busy(busy), .powered(powered), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // mode: 0 off, 1 powering up, 2 on, 3 powering down; ph counts cycles since the first write
    task automatic tick(input logic su, input logic sd, input logic f, input logic r);
        logic [8:0] vb_e;
        logic [7:0] md_e;
        int k;
        start_up = su; start_down = sd; fault = f; n_rst = r;
        @(posedge clk);
        cyc++;
        done_e = 1'b0;
        if (!r) begin
            mode = 0; ph = 0;
        end else if (mode == 0) begin
            if (su && !f) begin mode = 1; ph = 0; end
        end else if (mode == 1) begin
            if (sd || f) begin mode = 3; ph = 0; end
            else if (ph == LAST) begin mode = 2; done_e = 1'b1; end
            else ph++;
        end else if (mode == 2) begin
            if (sd || f) begin mode = 3; ph = 0; end
        end else begin
            if (ph == LAST) begin mode = 0; done_e = 1'b1; end
            else ph++;
        end
        #1;
        vb_e = 9'd0;
        md_e = 8'd0;
        if ((mode == 1 || mode == 3) && (ph % (D + 1) == 0)) begin
            k = ph / (D + 1);
            vb_e = 9'(1) << (mode == 1 ? up_ch[k] : dn_ch[k]);
            md_e = 8'(mode == 1 ? up_dat[k] : dn_dat[k]);
        end
        chk("valid_bus", 32'(valid_bus), 32'(vb_e));
        chk("master_data", 32'(master_data), 32'(md_e));
        chk("busy", 32'(busy), 32'(mode == 1 || mode == 3));
        chk("powered", 32'(powered), 32'(mode == 2));
        chk("done", 32'(done), 32'(done_e));
        chk("onehot0", 32'($onehot0(valid_bus)), 32'd1);
        if (valid_bus != 9'd0) begin last_wr = cyc; n_wr++; end
        if (done === 1'b1) last_done = cyc;
        if (powered === 1'b1) pw_seen = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, flt, 1'b1);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick(1'b0, 1'b0, flt, 1'b1);
    endtask

    initial begin
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        run_to(10);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("up_first_wr", last_wr, 11);
        run_to(40);
        chk("up_done_cyc", last_done, 36);
        chk("up_powered", 32'(powered), 1);
        run_to(50);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("dn_first_wr", last_wr, 51);
        run_to(80);
        chk("dn_done_cyc", last_done, 76);
        chk("dn_powered", 32'(powered), 0);

        pw_seen = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        t0 = cyc;
        run_to(t0 + 12);
        n_wr = 0;
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("abort_wr", last_wr, t0 + 13);
        idle(30);
        chk("abort_wr_cnt", n_wr, 5);
        chk("abort_no_power", 32'(pw_seen), 0);

        tick(1'b1, 1'b0, 1'b0, 1'b1);
        t0 = cyc;
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("abort_on_write", last_wr, t0 + 1);
        idle(30);

        pw_seen = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        t0 = cyc;
        run_to(t0 + 24);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk("abort_final_wait", last_wr, t0 + 25);
        idle(30);
        chk("abort_final_no_power", 32'(pw_seen), 0);

        tick(1'b1, 1'b0, 1'b0, 1'b1);
        idle(30);
        flt = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        chk("fault_wr", last_wr, cyc);
        idle(10);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        idle(30);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);
        chk("fault_off_busy", 32'(busy), 0);
        chk("fault_off_powered", 32'(powered), 0);
        flt = 1'b0;
        idle(2);

        tick(1'b1, 1'b0, 1'b0, 1'b1);
        t0 = cyc;
        run_to(t0 + 17);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_busy", 32'(busy), 0);
        n_wr = 0;
        idle(30);
        chk("rst_no_wr", n_wr, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_restart_wr", last_wr, cyc);
        idle(30);
        chk("rst_restart_powered", 32'(powered), 1);

        tick(1'b1, 1'b1, 1'b0, 1'b1);
        chk("simul_on_ch", 32'(valid_bus), 32'h010);
        idle(30);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        chk("simul_off_ch", 32'(valid_bus), 32'h100);
        idle(30);

        repeat (4000) begin
            if ($urandom_range(0, 149) == 0) flt = ~flt;
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, flt,
                 $urandom_range(0, 399) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
